// File: rtl/trap_ctrl_pkg.sv
// Shared constants, CSR addresses and FSM encoding for the machine-mode trap sequencer.
package trap_ctrl_pkg;
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_HI   = 12;
  localparam int MSTATUS_MPP_LO   = 11;

  localparam int IRQ_MSI = 3;
  localparam int IRQ_MTI = 7;
  localparam int IRQ_MEI = 11;

  localparam logic [3:0] EXC_ILLEGAL       = 4'd2;
  localparam logic [3:0] EXC_BREAKPOINT    = 4'd3;
  localparam logic [3:0] EXC_LOAD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_ECALL_M       = 4'd11;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  typedef enum logic [2:0] {
    ST_IDLE, ST_W_MEPC, ST_W_MCAUSE, ST_W_MTVAL, ST_W_MSTATUS, ST_M_STATUS, ST_REDIR
  } trap_state_e;

  typedef struct packed {
    logic       intr;
    logic       mret;
    logic [3:0] code;
  } trap_cause_t;
endpackage

// File: rtl/trap_ctrl_if.sv
// WB/CSR-side signal bundle of the trap sequencer; slave = sequencer, master = pipeline/CSR side.
interface trap_ctrl_if #(parameter int DATA_WIDTH = 32, parameter int CSR_ADDR_WIDTH = 12);
  logic                      wb_valid_i;
  logic [DATA_WIDTH-1:0]     wb_pc_i;
  logic                      exc_valid_i;
  logic [3:0]                exc_code_i;
  logic [DATA_WIDTH-1:0]     exc_tval_i;
  logic                      mret_i;
  logic                      irq_sw_i;
  logic                      irq_timer_i;
  logic                      irq_ext_i;
  logic [DATA_WIDTH-1:0]     mstatus_i;
  logic [DATA_WIDTH-1:0]     mie_i;
  logic [DATA_WIDTH-1:0]     mtvec_i;
  logic [DATA_WIDTH-1:0]     mepc_i;
  logic                      kill_wb_o;
  logic                      stall_o;
  logic                      csr_we_o;
  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o;
  logic [DATA_WIDTH-1:0]     csr_wdata_o;
  logic                      redirect_o;
  logic [DATA_WIDTH-1:0]     redirect_pc_o;
  logic [DATA_WIDTH-1:0]     mip_o;

  modport slave (
    input  wb_valid_i, wb_pc_i, exc_valid_i, exc_code_i, exc_tval_i, mret_i,
           irq_sw_i, irq_timer_i, irq_ext_i, mstatus_i, mie_i, mtvec_i, mepc_i,
    output kill_wb_o, stall_o, csr_we_o, csr_waddr_o, csr_wdata_o,
           redirect_o, redirect_pc_o, mip_o
  );

  modport master (
    output wb_valid_i, wb_pc_i, exc_valid_i, exc_code_i, exc_tval_i, mret_i,
           irq_sw_i, irq_timer_i, irq_ext_i, mstatus_i, mie_i, mtvec_i, mepc_i,
    input  kill_wb_o, stall_o, csr_we_o, csr_waddr_o, csr_wdata_o,
           redirect_o, redirect_pc_o, mip_o
  );
endinterface

// File: rtl/trap_irq_sel.sv
// Interrupt enable/priority picker: MEI > MSI > MTI, gated by a global enable.
module trap_irq_sel
  import trap_ctrl_pkg::*;
(
  input  logic       en_i,
  input  logic       mie_msi_i,
  input  logic       mie_mti_i,
  input  logic       mie_mei_i,
  input  logic       irq_sw_i,
  input  logic       irq_timer_i,
  input  logic       irq_ext_i,
  output logic       irq_take_o,
  output logic [3:0] irq_code_o
);
  logic mei, msi, mti;

  assign mei = en_i & mie_mei_i & irq_ext_i;
  assign msi = en_i & mie_msi_i & irq_sw_i;
  assign mti = en_i & mie_mti_i & irq_timer_i;

  always_comb begin
    irq_take_o = 1'b1;
    irq_code_o = 4'(IRQ_MEI);
    if (mei)      irq_code_o = 4'(IRQ_MEI);
    else if (msi) irq_code_o = 4'(IRQ_MSI);
    else if (mti) irq_code_o = 4'(IRQ_MTI);
    else begin
      irq_take_o = 1'b0;
      irq_code_o = 4'd0;
    end
  end
endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: kills the WB instruction, serializes mepc/mcause/mtval/mstatus
// writes through the single CSR write port, then issues a one-cycle PC redirect.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 12
)(
  input  logic        clk_i,
  input  logic        rst_ni,
  trap_ctrl_if.slave  bus
);
  localparam int DW = DATA_WIDTH;

  trap_state_e    state_q, state_d;
  trap_cause_t    cause_q, cause_d;
  logic [DW-1:0]  pc_q, pc_d, tval_q, tval_d, mip_q, mip_d;
  logic           irq_take, exc_take, mret_take;
  logic [3:0]     irq_code;
  logic [DW-1:0]  mst_trap, mst_mret, vec_base, vec_off;
  logic           unused_bits;

  assign unused_bits = ^{bus.mie_i, bus.mstatus_i};

  trap_irq_sel u_irq_sel (
    .en_i        (bus.wb_valid_i & bus.mstatus_i[MSTATUS_MIE_BIT]),
    .mie_msi_i   (bus.mie_i[IRQ_MSI]),
    .mie_mti_i   (bus.mie_i[IRQ_MTI]),
    .mie_mei_i   (bus.mie_i[IRQ_MEI]),
    .irq_sw_i    (bus.irq_sw_i),
    .irq_timer_i (bus.irq_timer_i),
    .irq_ext_i   (bus.irq_ext_i),
    .irq_take_o  (irq_take),
    .irq_code_o  (irq_code)
  );

  // Reset gating keeps the combinational kill/stall quiet while rst_ni is held low.
  assign exc_take  = rst_ni & bus.wb_valid_i & bus.exc_valid_i;
  assign mret_take = rst_ni & bus.wb_valid_i & bus.mret_i & ~bus.exc_valid_i;

  always_comb begin
    mst_trap                   = bus.mstatus_i;
    mst_trap[MSTATUS_MPIE_BIT] = bus.mstatus_i[MSTATUS_MIE_BIT];
    mst_trap[MSTATUS_MIE_BIT]  = 1'b0;
    mst_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mst_mret                   = bus.mstatus_i;
    mst_mret[MSTATUS_MIE_BIT]  = bus.mstatus_i[MSTATUS_MPIE_BIT];
    mst_mret[MSTATUS_MPIE_BIT] = 1'b1;
    mst_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  // Only vectored mode with an interrupt cause adds an offset; modes 2/3 behave as direct.
  assign vec_base = {bus.mtvec_i[DW-1:2], 2'b00};
  assign vec_off  = (bus.mtvec_i[1:0] == 2'b01 && cause_q.intr) ?
                    {{(DW-6){1'b0}}, cause_q.code, 2'b00} : '0;

  always_comb begin
    mip_d          = '0;
    mip_d[IRQ_MEI] = bus.irq_ext_i;
    mip_d[IRQ_MTI] = bus.irq_timer_i;
    mip_d[IRQ_MSI] = bus.irq_sw_i;
  end

  always_comb begin
    state_d           = state_q;
    cause_d           = cause_q;
    pc_d              = pc_q;
    tval_d            = tval_q;
    bus.kill_wb_o     = 1'b0;
    bus.stall_o       = 1'b0;
    bus.csr_we_o      = 1'b0;
    bus.csr_waddr_o   = '0;
    bus.csr_wdata_o   = '0;
    bus.redirect_o    = 1'b0;
    bus.redirect_pc_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (exc_take) begin
          state_d = ST_W_MEPC;
          cause_d = '{intr: 1'b0, mret: 1'b0, code: bus.exc_code_i};
          pc_d    = bus.wb_pc_i;
          tval_d  = bus.exc_tval_i;
        end else if (mret_take) begin
          state_d = ST_M_STATUS;
          cause_d = '{intr: 1'b0, mret: 1'b1, code: 4'd0};
        end else if (rst_ni && irq_take) begin
          state_d = ST_W_MEPC;
          cause_d = '{intr: 1'b1, mret: 1'b0, code: irq_code};
          pc_d    = bus.wb_pc_i;
          tval_d  = '0;
        end
        bus.kill_wb_o = (state_d != ST_IDLE);
        bus.stall_o   = (state_d != ST_IDLE);
      end
      ST_W_MEPC: begin
        bus.stall_o = 1'b1; bus.csr_we_o = 1'b1;
        bus.csr_waddr_o = CSR_ADDR_WIDTH'(CSR_MEPC);
        bus.csr_wdata_o = pc_q;
        state_d = ST_W_MCAUSE;
      end
      ST_W_MCAUSE: begin
        bus.stall_o = 1'b1; bus.csr_we_o = 1'b1;
        bus.csr_waddr_o = CSR_ADDR_WIDTH'(CSR_MCAUSE);
        bus.csr_wdata_o = {cause_q.intr, {(DW-5){1'b0}}, cause_q.code};
        state_d = ST_W_MTVAL;
      end
      ST_W_MTVAL: begin
        bus.stall_o = 1'b1; bus.csr_we_o = 1'b1;
        bus.csr_waddr_o = CSR_ADDR_WIDTH'(CSR_MTVAL);
        bus.csr_wdata_o = tval_q;
        state_d = ST_W_MSTATUS;
      end
      ST_W_MSTATUS: begin
        bus.stall_o = 1'b1; bus.csr_we_o = 1'b1;
        bus.csr_waddr_o = CSR_ADDR_WIDTH'(CSR_MSTATUS);
        bus.csr_wdata_o = mst_trap;
        state_d = ST_REDIR;
      end
      ST_M_STATUS: begin
        bus.stall_o = 1'b1; bus.csr_we_o = 1'b1;
        bus.csr_waddr_o = CSR_ADDR_WIDTH'(CSR_MSTATUS);
        bus.csr_wdata_o = mst_mret;
        state_d = ST_REDIR;
      end
      ST_REDIR: begin
        bus.stall_o       = 1'b1;
        bus.redirect_o    = 1'b1;
        bus.redirect_pc_o = cause_q.mret ? (bus.mepc_i & ~DW'(3)) : (vec_base + vec_off);
        state_d           = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cause_q <= '0;
      pc_q    <= '0;
      tval_q  <= '0;
      mip_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      tval_q  <= tval_d;
      mip_q   <= mip_d;
    end
  end

  assign bus.mip_o = mip_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: exception, vectored interrupt, MRET, priority, masking, mid-sequence reset.
module tb_trap_ctrl;
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b1;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  trap_ctrl_if bus();
  trap_ctrl dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus.slave));

  always #5 clk_i = ~clk_i;

  task automatic clr_pipe();
    bus.wb_valid_i = 0; bus.wb_pc_i = 0; bus.exc_valid_i = 0; bus.exc_code_i = 0;
    bus.exc_tval_i = 0; bus.mret_i = 0; bus.irq_sw_i = 0; bus.irq_timer_i = 0; bus.irq_ext_i = 0;
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  function automatic logic [44:0] wr();
    return {bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o};
  endfunction

  function automatic logic [79:0] outs();
    return {bus.kill_wb_o, bus.stall_o, bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o,
            bus.redirect_o, bus.redirect_pc_o};
  endfunction

  task automatic test_reset();
    clr_pipe(); bus.mstatus_i = 0; bus.mie_i = 0; bus.mtvec_i = 0; bus.mepc_i = 0;
    #2 rst_ni = 0; #1;
    tot_cnt++; if (outs() !== 80'h0) $display("FAIL rst_outs got=%h exp=0", outs()); else pass_cnt++;
    tot_cnt++; if (bus.mip_o !== 32'h0) $display("FAIL rst_mip got=%h exp=0", bus.mip_o); else pass_cnt++;
    tick(); tick(); rst_ni = 1;
  endtask

  task automatic test_illegal();
    tick(); bus.mtvec_i = 32'h200; bus.mstatus_i = 32'h8;
    bus.wb_valid_i = 1; bus.exc_valid_i = 1; bus.exc_code_i = 4'd2; bus.exc_tval_i = 32'h13; bus.wb_pc_i = 32'h100;
    #1;
    tot_cnt++; if ({bus.kill_wb_o, bus.stall_o, bus.csr_we_o} !== 3'b110)
      $display("FAIL ill_accept got=%b exp=110", {bus.kill_wb_o, bus.stall_o, bus.csr_we_o}); else pass_cnt++;
    tick(); clr_pipe(); #1;
    tot_cnt++; if ({bus.stall_o, wr()} !== {1'b1, 1'b1, 12'h341, 32'h100}) $display("FAIL ill_mepc got=%h", wr()); else pass_cnt++;
    tick(); #1;
    tot_cnt++; if (wr() !== {1'b1, 12'h342, 32'h2}) $display("FAIL ill_mcause got=%h exp=1342_00000002", wr()); else pass_cnt++;
    tick(); #1;
    tot_cnt++; if (wr() !== {1'b1, 12'h343, 32'h13}) $display("FAIL ill_mtval got=%h exp=1343_00000013", wr()); else pass_cnt++;
    tick(); #1;
    tot_cnt++; if (wr() !== {1'b1, 12'h300, 32'h1880}) $display("FAIL ill_mstatus got=%h exp=1300_00001880", wr()); else pass_cnt++;
    tick(); #1;
    tot_cnt++; if ({bus.redirect_o, bus.redirect_pc_o, bus.csr_we_o, bus.stall_o} !== {1'b1, 32'h200, 1'b0, 1'b1})
      $display("FAIL ill_redir got=%b/%h exp=1/200", bus.redirect_o, bus.redirect_pc_o); else pass_cnt++;
    tick(); #1;
    tot_cnt++; if ({bus.stall_o, bus.redirect_o, bus.csr_we_o} !== 3'b000)
      $display("FAIL ill_idle got=%b exp=000", {bus.stall_o, bus.redirect_o, bus.csr_we_o}); else pass_cnt++;
  endtask

  task automatic test_vec_timer();
    tick(); bus.mtvec_i = 32'h201; bus.mstatus_i = 32'h8; bus.mie_i = 32'h80;
    bus.wb_valid_i = 1; bus.irq_timer_i = 1; bus.wb_pc_i = 32'h40;
    #1;
    tot_cnt++; if ({bus.kill_wb_o, bus.stall_o} !== 2'b11) $display("FAIL tmr_accept got=%b exp=11", {bus.kill_wb_o, bus.stall_o}); else pass_cnt++;
    tick(); clr_pipe(); #1;
    tot_cnt++; if (wr() !== {1'b1, 12'h341, 32'h40}) $display("FAIL tmr_mepc got=%h exp=1341_00000040", wr()); else pass_cnt++;
    tick(); #1;
    tot_cnt++; if (wr() !== {1'b1, 12'h342, 32'h80000007}) $display("FAIL tmr_mcause got=%h exp=1342_80000007", wr()); else pass_cnt++;
    tick(); #1;
    tot_cnt++; if (wr() !== {1'b1, 12'h343, 32'h0}) $display("FAIL tmr_mtval got=%h exp=1343_00000000", wr()); else pass_cnt++;
    tick(); tick(); #1;
    tot_cnt++; if ({bus.redirect_o, bus.redirect_pc_o} !== {1'b1, 32'h21C})
      $display("FAIL tmr_redir got=%b/%h exp=1/21c", bus.redirect_o, bus.redirect_pc_o); else pass_cnt++;
    tick();
  endtask

  task automatic test_mret();
    tick(); bus.mstatus_i = 32'h80; bus.mepc_i = 32'h104; bus.mtvec_i = 32'h200;
    bus.wb_valid_i = 1; bus.mret_i = 1;
    #1;
    tot_cnt++; if ({bus.kill_wb_o, bus.stall_o} !== 2'b11) $display("FAIL mret_accept got=%b exp=11", {bus.kill_wb_o, bus.stall_o}); else pass_cnt++;
    tick(); clr_pipe(); #1;
    tot_cnt++; if (wr() !== {1'b1, 12'h300, 32'h1888}) $display("FAIL mret_mstatus got=%h exp=1300_00001888", wr()); else pass_cnt++;
    tick(); #1;
    tot_cnt++; if ({bus.redirect_o, bus.redirect_pc_o, bus.csr_we_o} !== {1'b1, 32'h104, 1'b0})
      $display("FAIL mret_redir got=%b/%h exp=1/104", bus.redirect_o, bus.redirect_pc_o); else pass_cnt++;
    tick(); #1;
    tot_cnt++; if (bus.stall_o !== 1'b0) $display("FAIL mret_stall_end got=%b exp=0", bus.stall_o); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    tick(); bus.mstatus_i = 32'h8; bus.mie_i = 32'h800; bus.mtvec_i = 32'h200; bus.mepc_i = 32'h104;
    bus.wb_valid_i = 1; bus.exc_valid_i = 1; bus.exc_code_i = 4'd11; bus.mret_i = 1;
    bus.irq_ext_i = 1; bus.wb_pc_i = 32'h300;
    #1;
    tot_cnt++; if (bus.kill_wb_o !== 1'b1) $display("FAIL b2b_accept got=%b exp=1", bus.kill_wb_o); else pass_cnt++;
    tick(); bus.exc_valid_i = 0; bus.mret_i = 0; #1;
    tot_cnt++; if (wr() !== {1'b1, 12'h341, 32'h300}) $display("FAIL b2b_mepc got=%h exp=1341_00000300", wr()); else pass_cnt++;
    tick(); #1;
    tot_cnt++; if (wr() !== {1'b1, 12'h342, 32'hB}) $display("FAIL b2b_mcause got=%h exp=1342_0000000b", wr()); else pass_cnt++;
    tick(); tick(); tick(); #1;
    tot_cnt++; if ({bus.redirect_o, bus.redirect_pc_o, bus.kill_wb_o} !== {1'b1, 32'h200, 1'b0})
      $display("FAIL b2b_redir got=%b/%h exp=1/200", bus.redirect_o, bus.redirect_pc_o); else pass_cnt++;
    tick(); #1;
    tot_cnt++; if ({bus.kill_wb_o, bus.stall_o, bus.redirect_o} !== 3'b110)
      $display("FAIL b2b_irq_accept got=%b exp=110", {bus.kill_wb_o, bus.stall_o, bus.redirect_o}); else pass_cnt++;
    tick(); clr_pipe(); tick(); #1;
    tot_cnt++; if (wr() !== {1'b1, 12'h342, 32'h8000000B}) $display("FAIL b2b_irq_mcause got=%h exp=1342_8000000b", wr()); else pass_cnt++;
    tick(); tick(); tick(); #1;
    tot_cnt++; if ({bus.redirect_o, bus.redirect_pc_o} !== {1'b1, 32'h200})
      $display("FAIL b2b_irq_redir got=%b/%h exp=1/200", bus.redirect_o, bus.redirect_pc_o); else pass_cnt++;
    tick();
  endtask

  task automatic test_masking();
    int bad;
    tick(); bus.mstatus_i = 32'h0; bus.mie_i = 32'h80; bus.wb_valid_i = 1; bus.irq_timer_i = 1; bus.wb_pc_i = 32'h80;
    #1;
    tot_cnt++; if (bus.mip_o[7] !== 1'b0) $display("FAIL mip_early got=%b exp=0", bus.mip_o[7]); else pass_cnt++;
    tick(); #1;
    tot_cnt++; if (bus.mip_o !== 32'h80) $display("FAIL mip_latency got=%h exp=80", bus.mip_o); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 20; i++) begin tick(); #1; if (bus.kill_wb_o || bus.stall_o) bad++; end
    tot_cnt++; if (bad != 0) $display("FAIL mask_mie0 got=%0d active cycles exp=0", bad); else pass_cnt++;
    bus.mstatus_i = 32'h8; bus.mie_i = 32'h0; bad = 0;
    for (int i = 0; i < 20; i++) begin tick(); #1; if (bus.kill_wb_o || bus.stall_o) bad++; end
    tot_cnt++; if (bad != 0) $display("FAIL mask_mie7 got=%0d active cycles exp=0", bad); else pass_cnt++;
    bus.mie_i = 32'h80; bus.wb_valid_i = 0; bus.exc_valid_i = 1; bad = 0;
    for (int i = 0; i < 5; i++) begin tick(); #1; if (bus.kill_wb_o || bus.stall_o) bad++; end
    tot_cnt++; if (bad != 0) $display("FAIL no_wb_valid got=%0d active cycles exp=0", bad); else pass_cnt++;
    clr_pipe();
  endtask

  task automatic test_reset_mid();
    int bad;
    tick(); bus.mtvec_i = 32'h200; bus.mstatus_i = 32'h8; bus.mie_i = 0;
    bus.wb_valid_i = 1; bus.exc_valid_i = 1; bus.exc_code_i = 4'd4; bus.exc_tval_i = 32'hDEAD; bus.wb_pc_i = 32'h500;
    tick(); clr_pipe(); tick(); #1;
    tot_cnt++; if (wr() !== {1'b1, 12'h342, 32'h4}) $display("FAIL rmid_mcause got=%h exp=1342_00000004", wr()); else pass_cnt++;
    #1 rst_ni = 0; #1;
    tot_cnt++; if (outs() !== 80'h0) $display("FAIL rmid_outs got=%h exp=0", outs()); else pass_cnt++;
    tick(); tick(); rst_ni = 1; bad = 0;
    for (int i = 0; i < 10; i++) begin tick(); #1; if (bus.csr_we_o || bus.redirect_o || bus.stall_o) bad++; end
    tot_cnt++; if (bad != 0) $display("FAIL rmid_quiet got=%0d active cycles exp=0", bad); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_vec_timer();
    test_mret();
    test_back_to_back();
    test_masking();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
